time_setter: RTL and testbench
==============================

# time_setter

Front-panel time-entry controller: the writer side of the clock counter's set interface (`select`, `select_enable`, `num`). It turns three push-buttons into an edited HH:MM:SS value and commits it digit by digit into the clock. It runs on the fast panel clock, snapshots the live time when editing starts, and aborts silently on inactivity.

## Interface
Parameters:
- `DB_CYCLES`, 20: stable-sample count for button debounce.
- `HOLD_CYCLES`, 1100: cycles each commit write is held. Must cover more than one `CLK_1Hz` period.
- `TIMEOUT`, 15000: idle cycles in EDIT before abort.

Ports:
- `CLK_1kHz` in 1: panel clock. It is the only clock in the block.
- `reset` in 1: asynchronous, active-high.
- `btn_mode`, `btn_next`, `btn_up` in 1 each: raw buttons, active-high, asynchronous to `CLK_1kHz`.
- `second_d`, `second_g`, `minute_d`, `minute_g`, `hour_d`, `hour_g` in 4 each: live BCD digits from the clock. `_d` is the ones digit, `_g` is the tens digit.
- `select` out 3: target digit code. 0 = sec ones, 1 = sec tens, 3 = min ones, 4 = min tens, 6 = hour ones, 7 = hour tens.
- `select_enable` out 1: write strobe, level-held.
- `num` out 4: BCD value to write.
- `editing` out 1: high in EDIT and COMMIT.
- `cursor` out 3: select code of the digit under edit, used for display blink.

## Operation
Button inputs:
- Each button passes through a 2-FF synchronizer, then a debouncer. A level change is accepted only after `DB_CYCLES` consecutive equal samples.
- Each accepted rising edge produces exactly one 1-cycle pulse. There is no auto-repeat.

FSM has three states.

IDLE:
- `mode` pulse: latch all six live digits into the edit registers, set `cursor`=7, clear the timeout counter, go to EDIT.
- `next` and `up` pulses are ignored.

EDIT:
- Pulse priority is mode > next > up. Lower-priority pulses in the same cycle are dropped.
- `next`: cursor moves 7→6→4→3→1→0→7 (wraps).
- `up`: increments the digit under the cursor, wrapping to 0 past its limit.
  - Tens of sec/min: 5.
  - Ones of sec/min: 9.
  - `hour_g`: 2.
  - `hour_d`: 9, or 3 when edit `hour_g`==2.
- Clamp rules keep the edited hour in 00–23 at all times:
  - `hour_g` becoming 2 while `hour_d`>3 forces `hour_d`=3 in the same cycle.
  - `up` on `hour_d`==3 with `hour_g`==2 wraps it to 0.
- Any pulse clears the timeout counter.
- `mode` goes to COMMIT.
- Timeout counter reaching `TIMEOUT` goes to IDLE with no write.

COMMIT:
- Six write slots in the order sec_d, sec_g, min_d, min_g, hour_d, hour_g.
- Each slot drives `select`/`num` for exactly `HOLD_CYCLES` cycles.
- `select_enable` stays high across all slots.
- All buttons are ignored.
- After the last slot, go to IDLE.

Other rules:
- Edit registers are 4 bits and never hold a non-BCD or out-of-range value.
- 24-hour format only. 12-hour conversion is outside this block.

## Timing
Reset values (asynchronous):
- `select`=0, `num`=0, `select_enable`=0, `editing`=0, `cursor`=7.
- State IDLE, all counters 0.
- Reset asserted mid-COMMIT drops `select_enable` immediately. The partially written time stays as written.

Button latency: raw edge to pulse is 2 + `DB_CYCLES` cycles.

EDIT entry:
- The snapshot is taken on the same edge that moves the FSM to EDIT.
- `editing` rises on the following cycle.

Commit write timing:
- COMMIT entry: `select_enable` and first-slot `select`/`num` are registered on the edge after the mode pulse.
- `select`/`num` change only on slot boundaries, every `HOLD_CYCLES` cycles.
- Total assertion is 6×`HOLD_CYCLES` cycles.
- On the cycle after the last slot: `select_enable`=0, `editing`=0, `select`=0, `num`=0.

All outputs are registered. No combinational path from inputs to outputs.

## Structure
- `clock_pkg` holds:
  - select-code constants `SEL_SEC_D`=0, `SEL_SEC_G`=1, `SEL_MIN_D`=3, `SEL_MIN_G`=4, `SEL_HOUR_D`=6, `SEL_HOUR_G`=7;
  - the digit-limit constants;
  - the state enum IDLE/EDIT/COMMIT.
- One sub-module, `btn_debounce` (synchronizer + stable counter + edge pulse), instantiated three times.
- FSM, edit registers, timeout counter and slot/hold counters live in `time_setter`.

## Test plan
Run with `DB_CYCLES`=2, `HOLD_CYCLES`=4, `TIMEOUT`=50.

- **Snapshot and commit:** live 12:34:56, then mode, mode. Expect `select_enable` high for 24 cycles. Writes in order are (0,6), (1,5), (3,4), (4,3), (6,2), (7,1), then `editing`=0.
- **Hour clamp:** snapshot 19:00:00, edit `hour_g` up once. Expect edit hour becomes 23, and `up` on `hour_d` then wraps it to 0 (commit shows 20).
- **Digit wrap and cursor:** next ×5 reaches `cursor`=0; a 6th next gives 7. Sec tens at 5, then up, gives 0.
- **Timeout:** enter EDIT and press nothing for 50 cycles. Expect IDLE, `select_enable` never asserted.
- **Reset mid-COMMIT:** assert `reset` in slot 3. Expect all outputs at reset values in the same cycle, and no further writes.
- **Bounce and simultaneous presses:** a 1-cycle glitch on `btn_up` gives no pulse. Simultaneous mode+up in EDIT enters COMMIT with the digit unchanged.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared constants, state type and helpers for the clock front panel.
// Select codes address one BCD digit of the clock counter. Edit digits are kept as a
// packed 6-entry array indexed in commit order: sec_d, sec_g, min_d, min_g, hour_d, hour_g.
package clock_pkg;

  localparam logic [2:0] SEL_SEC_D  = 3'd0;
  localparam logic [2:0] SEL_SEC_G  = 3'd1;
  localparam logic [2:0] SEL_MIN_D  = 3'd3;
  localparam logic [2:0] SEL_MIN_G  = 3'd4;
  localparam logic [2:0] SEL_HOUR_D = 3'd6;
  localparam logic [2:0] SEL_HOUR_G = 3'd7;

  localparam logic [3:0] LIM_ONES      = 4'd9;  // ones of sec/min/hour
  localparam logic [3:0] LIM_TENS      = 4'd5;  // tens of sec/min
  localparam logic [3:0] LIM_HOUR_G    = 4'd2;  // hour tens
  localparam logic [3:0] LIM_HOUR_D_HI = 4'd3;  // hour ones when hour tens is 2

  localparam logic [2:0] IDX_HOUR_D = 3'd4;
  localparam logic [2:0] IDX_HOUR_G = 3'd5;
  localparam logic [2:0] LAST_SLOT  = 3'd5;

  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_e;

  // Cursor order 7 -> 6 -> 4 -> 3 -> 1 -> 0 -> 7.
  function automatic logic [2:0] next_cursor(input logic [2:0] c);
    case (c)
      SEL_HOUR_G: next_cursor = SEL_HOUR_D;
      SEL_HOUR_D: next_cursor = SEL_MIN_G;
      SEL_MIN_G:  next_cursor = SEL_MIN_D;
      SEL_MIN_D:  next_cursor = SEL_SEC_G;
      SEL_SEC_G:  next_cursor = SEL_SEC_D;
      default:    next_cursor = SEL_HOUR_G;
    endcase
  endfunction

  function automatic logic [2:0] idx_to_sel(input logic [2:0] idx);
    case (idx)
      3'd0:    idx_to_sel = SEL_SEC_D;
      3'd1:    idx_to_sel = SEL_SEC_G;
      3'd2:    idx_to_sel = SEL_MIN_D;
      3'd3:    idx_to_sel = SEL_MIN_G;
      3'd4:    idx_to_sel = SEL_HOUR_D;
      default: idx_to_sel = SEL_HOUR_G;
    endcase
  endfunction

  function automatic logic [2:0] sel_to_idx(input logic [2:0] sel);
    case (sel)
      SEL_SEC_D:  sel_to_idx = 3'd0;
      SEL_SEC_G:  sel_to_idx = 3'd1;
      SEL_MIN_D:  sel_to_idx = 3'd2;
      SEL_MIN_G:  sel_to_idx = 3'd3;
      SEL_HOUR_D: sel_to_idx = 3'd4;
      default:    sel_to_idx = 3'd5;
    endcase
  endfunction

  // Largest legal value of a digit; hour ones depends on the current hour tens.
  function automatic logic [3:0] digit_limit(input logic [2:0] idx, input logic [3:0] hour_g);
    case (idx)
      3'd0, 3'd2: digit_limit = LIM_ONES;
      3'd1, 3'd3: digit_limit = LIM_TENS;
      3'd4:       digit_limit = (hour_g == LIM_HOUR_G) ? LIM_HOUR_D_HI : LIM_ONES;
      default:    digit_limit = LIM_HOUR_G;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-sample debouncer and rising-edge pulse.
//   CLK_1kHz  in  panel clock
//   reset     in  asynchronous, active-high
//   btn       in  raw button, asynchronous
//   pulse     out one-cycle registered pulse per accepted rising edge
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 20
) (
  input  logic CLK_1kHz,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A new level is accepted on its DB_CYCLES-th consecutive differing sample.
  always_comb begin
    level_d = level_q;
    pulse_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_1kHz or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/time_setter.sv
// time_setter: front-panel time entry; snapshots live time, edits it with three
// buttons and commits it digit by digit through the clock's set interface.
//   CLK_1kHz, reset                  panel clock, async active-high reset
//   btn_mode, btn_next, btn_up       raw buttons
//   second_/minute_/hour_ d,g        live BCD digits (d = ones, g = tens)
//   select, select_enable, num       set interface (registered)
//   editing, cursor                  panel status (registered)
module time_setter
  import clock_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 20,
  parameter int unsigned HOLD_CYCLES = 1100,
  parameter int unsigned TIMEOUT     = 15000
) (
  input  logic       CLK_1kHz,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic [3:0] second_d,
  input  logic [3:0] second_g,
  input  logic [3:0] minute_d,
  input  logic [3:0] minute_g,
  input  logic [3:0] hour_d,
  input  logic [3:0] hour_g,
  output logic [2:0] select,
  output logic       select_enable,
  output logic [3:0] num,
  output logic       editing,
  output logic [2:0] cursor
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic mode_p, next_p, up_p;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .CLK_1kHz(CLK_1kHz), .reset(reset), .btn(btn_mode), .pulse(mode_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
    .CLK_1kHz(CLK_1kHz), .reset(reset), .btn(btn_next), .pulse(next_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .CLK_1kHz(CLK_1kHz), .reset(reset), .btn(btn_up), .pulse(up_p)
  );

  state_e          state_q, state_d;
  logic [5:0][3:0] digits_q, digits_d;
  logic [5:0][3:0] snap;
  logic [2:0]      cursor_q, cursor_d;
  logic [2:0]      cur_idx;
  logic [TW-1:0]   to_q, to_d;
  logic [2:0]      slot_q, slot_d, slot_n;
  logic [HW-1:0]   hold_q, hold_d;
  logic [2:0]      select_q, select_d;
  logic [3:0]      num_q, num_d;
  logic            en_q, en_d;
  logic            editing_q, editing_d;

  assign cur_idx = sel_to_idx(cursor_q);
  assign slot_n  = slot_q + 3'd1;

  // Snapshot with out-of-range live digits forced legal, so edits never start illegal.
  always_comb begin
    snap = {hour_g, hour_d, minute_g, minute_d, second_g, second_d};
    for (int i = 0; i < 6; i++) begin
      if (snap[i] > digit_limit(3'(i), 4'd0)) snap[i] = 4'd0;
    end
    if (snap[IDX_HOUR_G] == LIM_HOUR_G && snap[IDX_HOUR_D] > LIM_HOUR_D_HI) begin
      snap[IDX_HOUR_D] = LIM_HOUR_D_HI;
    end
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    cursor_d = cursor_q;
    to_d     = to_q;
    slot_d   = slot_q;
    hold_d   = hold_q;
    select_d = select_q;
    num_d    = num_q;
    en_d     = en_q;
    unique case (state_q)
      IDLE: begin
        if (mode_p) begin
          digits_d = snap;
          cursor_d = SEL_HOUR_G;
          to_d     = '0;
          state_d  = EDIT;
        end
      end
      EDIT: begin
        if (mode_p || next_p || up_p) begin
          to_d = '0;
        end else if (to_q == TO_LAST) begin
          to_d    = '0;
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
        if (mode_p) begin
          state_d  = COMMIT;
          en_d     = 1'b1;
          slot_d   = '0;
          hold_d   = '0;
          select_d = idx_to_sel(3'd0);
          num_d    = digits_q[0];
        end else if (next_p) begin
          cursor_d = next_cursor(cursor_q);
        end else if (up_p) begin
          if (digits_q[cur_idx] >= digit_limit(cur_idx, digits_q[IDX_HOUR_G])) begin
            digits_d[cur_idx] = 4'd0;
          end else begin
            digits_d[cur_idx] = digits_q[cur_idx] + 4'd1;
          end
          // Hour tens stepping to 2 pulls hour ones down so the hour stays <= 23.
          if (cur_idx == IDX_HOUR_G && digits_d[IDX_HOUR_G] == LIM_HOUR_G &&
              digits_q[IDX_HOUR_D] > LIM_HOUR_D_HI) begin
            digits_d[IDX_HOUR_D] = LIM_HOUR_D_HI;
          end
        end
      end
      COMMIT: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (slot_q == LAST_SLOT) begin
            state_d  = IDLE;
            en_d     = 1'b0;
            slot_d   = '0;
            select_d = '0;
            num_d    = '0;
          end else begin
            slot_d   = slot_n;
            select_d = idx_to_sel(slot_n);
            num_d    = digits_q[slot_n];
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    editing_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK_1kHz or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      digits_q  <= '0;
      cursor_q  <= SEL_HOUR_G;
      to_q      <= '0;
      slot_q    <= '0;
      hold_q    <= '0;
      select_q  <= '0;
      num_q     <= '0;
      en_q      <= 1'b0;
      editing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      cursor_q  <= cursor_d;
      to_q      <= to_d;
      slot_q    <= slot_d;
      hold_q    <= hold_d;
      select_q  <= select_d;
      num_q     <= num_d;
      en_q      <= en_d;
      editing_q <= editing_d;
    end
  end

  assign select        = select_q;
  assign num           = num_q;
  assign select_enable = en_q;
  assign editing       = editing_q;
  assign cursor        = cursor_q;

endmodule

// File: tb/tb_time_setter.sv
// tb_time_setter: directed test of time_setter with small debounce/hold/timeout values.
module tb_time_setter;

  logic       clk = 1'b0;
  logic       reset;
  logic       b_mode, b_next, b_up;
  logic [3:0] sd, sg, md, mg, hd, hg;
  logic [2:0] select;
  logic       select_enable;
  logic [3:0] num;
  logic       editing;
  logic [2:0] cursor;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  time_setter #(.DB_CYCLES(2), .HOLD_CYCLES(4), .TIMEOUT(50)) dut (
    .CLK_1kHz(clk), .reset(reset),
    .btn_mode(b_mode), .btn_next(b_next), .btn_up(b_up),
    .second_d(sd), .second_g(sg), .minute_d(md), .minute_g(mg), .hour_d(hd), .hour_g(hg),
    .select(select), .select_enable(select_enable), .num(num),
    .editing(editing), .cursor(cursor)
  );

  localparam logic [5:0][2:0] EXP_SEL = {3'd7, 3'd6, 3'd4, 3'd3, 3'd1, 3'd0};

  task automatic set_live(input logic [3:0] h1, h0, m1, m0, s1, s0);
    hg = h1; hd = h0; mg = m1; md = m0; sg = s1; sd = s0;
  endtask

  // b = {mode, next, up}; held 5 cycles, then released and allowed to settle.
  task automatic press(input logic [2:0] b);
    @(negedge clk);
    {b_mode, b_next, b_up} = b;
    repeat (5) @(negedge clk);
    {b_mode, b_next, b_up} = 3'b000;
    repeat (6) @(negedge clk);
  endtask

  // Presses b (which must include mode) and records the commit sequence.
  task automatic do_commit(input logic [2:0] b, output logic [5:0][2:0] sels,
                           output logic [5:0][3:0] nums, output logic [5:0][7:0] durs,
                           output int nwr, output int en_cyc, output logic post_ok,
                           output logic done);
    logic seen;
    logic [2:0] cur;
    sels = '0; nums = '0; durs = '0; nwr = 0; en_cyc = 0; post_ok = 1'b0; done = 1'b0;
    seen = 1'b0; cur = '0;
    @(negedge clk);
    {b_mode, b_next, b_up} = b;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (i == 5) {b_mode, b_next, b_up} = 3'b000;
      if (select_enable) begin
        en_cyc++;
        if (!seen || select != cur) begin
          if (nwr < 6) begin
            sels[nwr] = select; nums[nwr] = num; durs[nwr] = 8'd1;
          end
          nwr++;
          cur = select;
        end else if (nwr <= 6) begin
          durs[nwr-1] = durs[nwr-1] + 8'd1;
        end
        seen = 1'b1;
      end else if (seen) begin
        done    = 1'b1;
        post_ok = !editing && select == 3'd0 && num == 4'd0;
      end
    end
    {b_mode, b_next, b_up} = 3'b000;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    vec++;
    if ({select, num, select_enable, editing, cursor} !== {3'd0, 4'd0, 1'b0, 1'b0, 3'd7}) begin
      errs++;
      $display("FAIL reset_values: got sel=%0d num=%0d en=%0b ed=%0b cur=%0d, want 0 0 0 0 7",
               select, num, select_enable, editing, cursor);
    end
  endtask

  task automatic test_snapshot_commit;
    logic [5:0][2:0] s; logic [5:0][3:0] n; logic [5:0][7:0] d;
    int nw, ec; logic pok, dn;
    logic [5:0][3:0] exp_n;
    exp_n = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    set_live(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    press(3'b100);
    vec++;
    if (editing !== 1'b1 || cursor !== 3'd7) begin
      errs++;
      $display("FAIL edit_entry: got ed=%0b cur=%0d, want 1 7", editing, cursor);
    end
    // Live time changing after the snapshot must not leak into the commit.
    set_live(4'd0, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9);
    do_commit(3'b100, s, n, d, nw, ec, pok, dn);
    vec++;
    if (!dn || ec != 24 || nw != 6 || !pok) begin
      errs++;
      $display("FAIL commit_frame: got done=%0b en_cycles=%0d writes=%0d post_ok=%0b, want 1 24 6 1",
               dn, ec, nw, pok);
    end
    for (int i = 0; i < 6; i++) begin
      vec++;
      if (s[i] !== EXP_SEL[i] || n[i] !== exp_n[i] || d[i] !== 8'd4) begin
        errs++;
        $display("FAIL commit_write%0d: got (%0d,%0d) x%0d, want (%0d,%0d) x4",
                 i, s[i], n[i], d[i], EXP_SEL[i], exp_n[i]);
      end
    end
  endtask

  task automatic test_hour_clamp;
    logic [5:0][2:0] s; logic [5:0][3:0] n; logic [5:0][7:0] d;
    int nw, ec; logic pok, dn;
    set_live(4'd1, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0);
    press(3'b100);
    press(3'b001);
    do_commit(3'b100, s, n, d, nw, ec, pok, dn);
    vec++;
    if (!dn || n[5] !== 4'd2 || n[4] !== 4'd3 || n[0] !== 4'd0) begin
      errs++;
      $display("FAIL hour_clamp_23: got hour %0d%0d done=%0b, want 23", n[5], n[4], dn);
    end
    press(3'b100);
    press(3'b001);
    press(3'b010);
    press(3'b001);
    do_commit(3'b100, s, n, d, nw, ec, pok, dn);
    vec++;
    if (!dn || n[5] !== 4'd2 || n[4] !== 4'd0) begin
      errs++;
      $display("FAIL hour_d_wrap: got hour %0d%0d done=%0b, want 20", n[5], n[4], dn);
    end
  endtask

  task automatic test_cursor_wrap;
    logic [5:0][2:0] s; logic [5:0][3:0] n; logic [5:0][7:0] d;
    int nw, ec; logic pok, dn;
    logic [2:0] exp_c [6];
    logic [5:0][3:0] exp_n;
    exp_c = '{3'd6, 3'd4, 3'd3, 3'd1, 3'd0, 3'd7};
    exp_n = {4'd0, 4'd8, 4'd0, 4'd7, 4'd0, 4'd3};
    set_live(4'd0, 4'd8, 4'd0, 4'd7, 4'd5, 4'd3);
    press(3'b100);
    for (int i = 0; i < 6; i++) begin
      press(3'b010);
      vec++;
      if (cursor !== exp_c[i]) begin
        errs++;
        $display("FAIL cursor_step%0d: got %0d, want %0d", i, cursor, exp_c[i]);
      end
    end
    for (int i = 0; i < 4; i++) press(3'b010);
    press(3'b001);
    do_commit(3'b100, s, n, d, nw, ec, pok, dn);
    vec++;
    if (!dn || n !== exp_n) begin
      errs++;
      $display("FAIL sec_tens_wrap: got %h, want %h", n, exp_n);
    end
  endtask

  task automatic test_timeout;
    logic saw_en;
    saw_en = 1'b0;
    set_live(4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1);
    press(3'b100);
    repeat (40) begin
      @(negedge clk);
      if (select_enable) saw_en = 1'b1;
    end
    vec++;
    if (editing !== 1'b1) begin
      errs++;
      $display("FAIL timeout_early: got editing=%0b, want 1", editing);
    end
    repeat (20) begin
      @(negedge clk);
      if (select_enable) saw_en = 1'b1;
    end
    vec++;
    if (editing !== 1'b0 || saw_en !== 1'b0) begin
      errs++;
      $display("FAIL timeout_abort: got editing=%0b saw_en=%0b, want 0 0", editing, saw_en);
    end
  endtask

  task automatic test_reset_mid_commit;
    logic hit, saw_en;
    hit = 1'b0; saw_en = 1'b0;
    set_live(4'd2, 4'd1, 4'd4, 4'd5, 4'd3, 4'd8);
    press(3'b100);
    @(negedge clk);
    b_mode = 1'b1;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (i == 5) b_mode = 1'b0;
      if (select_enable && select == 3'd3) hit = 1'b1;
    end
    b_mode = 1'b0;
    vec++;
    if (!hit) begin
      errs++;
      $display("FAIL reset_reach_slot3: got slot3_seen=0, want 1");
    end
    reset = 1'b1;
    #1;
    vec++;
    if ({select, num, select_enable, editing, cursor} !== {3'd0, 4'd0, 1'b0, 1'b0, 3'd7}) begin
      errs++;
      $display("FAIL reset_mid_commit: got sel=%0d num=%0d en=%0b ed=%0b cur=%0d, want 0 0 0 0 7",
               select, num, select_enable, editing, cursor);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (select_enable) saw_en = 1'b1;
    end
    vec++;
    if (saw_en !== 1'b0 || editing !== 1'b0) begin
      errs++;
      $display("FAIL reset_no_more_writes: got saw_en=%0b ed=%0b, want 0 0", saw_en, editing);
    end
  endtask

  task automatic test_bounce_simultaneous;
    logic [5:0][2:0] s; logic [5:0][3:0] n; logic [5:0][7:0] d;
    int nw, ec; logic pok, dn;
    set_live(4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk); b_mode = 1'b1;
    @(negedge clk); b_mode = 1'b0;
    repeat (8) @(negedge clk);
    vec++;
    if (editing !== 1'b0) begin
      errs++;
      $display("FAIL glitch_mode: got editing=%0b, want 0", editing);
    end
    press(3'b100);
    @(negedge clk); b_up = 1'b1;
    @(negedge clk); b_up = 1'b0;
    repeat (8) @(negedge clk);
    do_commit(3'b101, s, n, d, nw, ec, pok, dn);
    vec++;
    if (!dn || ec != 24 || n[5] !== 4'd1 || n[4] !== 4'd0) begin
      errs++;
      $display("FAIL glitch_simul_up: got hour %0d%0d en_cycles=%0d done=%0b, want 10 24 1",
               n[5], n[4], ec, dn);
    end
  endtask

  initial begin
    reset = 1'b1;
    {b_mode, b_next, b_up} = 3'b000;
    set_live(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    #2;
    test_reset;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    test_snapshot_commit;
    test_hour_clamp;
    test_cursor_wrap;
    test_timeout;
    test_reset_mid_commit;
    test_bounce_simultaneous;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
